// File: rtl/ip_encode_if.sv
// Request/stream bundle for ip_encode: header request fields in, header bytes out.
// The master side drives requests and accepts bytes; the slave side is the encoder.
interface ip_encode_if;
    logic        start;
    logic [31:0] sa;
    logic [31:0] da;
    logic [7:0]  protocol;
    logic [15:0] payload_len;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output start, sa, da, protocol, payload_len, dout_ready,
        input  dout, dout_valid, busy, done, err
    );

    modport slave (
        input  start, sa, da, protocol, payload_len, dout_ready,
        output dout, dout_valid, busy, done, err
    );
endinterface

// File: rtl/ip_encode.sv
// IPv4 header encoder: latches a request, sums the header over 10 cycles, then streams 20 bytes.
// Define IP_ENCODE_ID_EN to carry a running identification count instead of a constant zero id.
module ip_encode (
    input  logic        clk,
    input  logic        rst,
    ip_encode_if.slave  bus
);
    localparam logic [1:0]  IDLE = 2'd0;
    localparam logic [1:0]  CSUM = 2'd1;
    localparam logic [1:0]  SEND = 2'd2;
    localparam logic [15:0] MAX_PAYLOAD = 16'd65515;

    logic [1:0]  state_reg;
    logic [4:0]  idx_reg;
    logic [15:0] acc_reg;
    logic [31:0] sa_reg;
    logic [31:0] da_reg;
    logic [7:0]  proto_reg;
    logic [15:0] total_len_reg;
    logic        done_reg;
    logic        err_reg;
    logic [15:0] id_val;

    logic        accept_start;
    logic        last_accept;
    logic [16:0] sum17;
    logic [15:0] acc_next;
    logic [15:0] sum_word [10];
    logic [15:0] tx_word  [10];
    logic [7:0]  hdr_byte [20];

    assign accept_start = (state_reg == IDLE) && bus.start && (bus.payload_len <= MAX_PAYLOAD);
    assign last_accept  = (state_reg == SEND) && bus.dout_ready && (idx_reg == 5'd19);

`ifdef IP_ENCODE_ID_EN
    logic [15:0] id_ctr_reg;
    logic [15:0] id_reg;

    // Counter advances on the edge that raises done, so a start in the done cycle sees the new id.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_ctr_reg <= 16'h0000;
            id_reg     <= 16'h0000;
        end else begin
            if (last_accept)
                id_ctr_reg <= id_ctr_reg + 16'd1;
            if (accept_start)
                id_reg <= id_ctr_reg;
        end
    end

    assign id_val = id_reg;
`else
    assign id_val = 16'h0000;
`endif

    // Header words as summed; the checksum slot counts as zero.
    always_comb begin
        sum_word[0] = 16'h4500;
        sum_word[1] = total_len_reg;
        sum_word[2] = id_val;
        sum_word[3] = 16'h4000;
        sum_word[4] = {8'h40, proto_reg};
        sum_word[5] = 16'h0000;
        sum_word[6] = sa_reg[31:16];
        sum_word[7] = sa_reg[15:0];
        sum_word[8] = da_reg[31:16];
        sum_word[9] = da_reg[15:0];
    end

    genvar gi;
    generate
        for (gi = 0; gi < 10; gi++) begin : g_bytes
            if (gi == 5) begin : g_csum
                assign tx_word[gi] = ~acc_reg;
            end else begin : g_field
                assign tx_word[gi] = sum_word[gi];
            end
            assign hdr_byte[2*gi]   = tx_word[gi][15:8];
            assign hdr_byte[2*gi+1] = tx_word[gi][7:0];
        end
    endgenerate

    // One's-complement add with the carry wrapped back into bit 0.
    assign sum17    = {1'b0, acc_reg} + {1'b0, sum_word[idx_reg[3:0]]};
    assign acc_next = sum17[15:0] + {15'd0, sum17[16]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            idx_reg       <= 5'd0;
            acc_reg       <= 16'h0000;
            sa_reg        <= 32'h0;
            da_reg        <= 32'h0;
            proto_reg     <= 8'h00;
            total_len_reg <= 16'h0000;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept_start) begin
                        sa_reg        <= bus.sa;
                        da_reg        <= bus.da;
                        proto_reg     <= bus.protocol;
                        total_len_reg <= bus.payload_len + 16'd20;
                        acc_reg       <= 16'h0000;
                        idx_reg       <= 5'd0;
                        state_reg     <= CSUM;
                    end else if (bus.start) begin
                        err_reg <= 1'b1;
                    end
                end
                CSUM: begin
                    acc_reg <= acc_next;
                    if (idx_reg == 5'd9) begin
                        idx_reg   <= 5'd0;
                        state_reg <= SEND;
                    end else begin
                        idx_reg <= idx_reg + 5'd1;
                    end
                end
                SEND: begin
                    if (last_accept) begin
                        idx_reg   <= 5'd0;
                        done_reg  <= 1'b1;
                        state_reg <= IDLE;
                    end else if (bus.dout_ready) begin
                        idx_reg <= idx_reg + 5'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.dout_valid = (state_reg == SEND);
    assign bus.dout       = (state_reg == SEND) ? hdr_byte[idx_reg] : 8'h00;
    assign bus.busy       = (state_reg != IDLE);
    assign bus.done       = done_reg;
    assign bus.err        = err_reg;
endmodule

// File: tb/tb_ip_encode.sv
// Bench for ip_encode: table of header requests checked against a byte scoreboard,
// plus hand-written sequences for length limit, reset abort, busy start and back-to-back.
module tb_ip_encode;
    typedef struct {
        logic [31:0] sa;
        logic [31:0] da;
        logic [7:0]  proto;
        logic [15:0] len;
        bit          bp;
        logic [15:0] exp_total;
        logic [15:0] exp_csum;
    } vec_t;

    logic clk;
    logic rst;
    ip_encode_if bus ();

    ip_encode u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  exp_q [$];
    logic [7:0]  got [20];
    int          nb = 0;
    bit          hold_pending = 0;
    logic [7:0]  held = 8'h00;
    logic [15:0] exp_id = 16'h0000;
    logic [3:0]  bp_pat = 4'b1001;
    vec_t        vecs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] fold(input logic [31:0] s);
        logic [31:0] t;
        t = (s & 32'hFFFF) + (s >> 16);
        t = (t & 32'hFFFF) + (t >> 16);
        return t[15:0];
    endfunction

    function automatic logic [7:0] model_byte(input int i, input vec_t v, input logic [15:0] id);
        logic [15:0] w [10];
        logic [31:0] s;
        logic [15:0] tl;
        tl = v.len + 16'd20;
        w = '{16'h4500, tl, id, 16'h4000, {8'h40, v.proto}, 16'h0000,
              v.sa[31:16], v.sa[15:0], v.da[31:16], v.da[15:0]};
        s = 0;
        for (int j = 0; j < 10; j++) s += {16'h0, w[j]};
        w[5] = ~fold(s);
        return i[0] ? w[i >> 1][7:0] : w[i >> 1][15:8];
    endfunction

    // Scoreboard monitor: sampled on the falling edge, mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (hold_pending) begin
                check("hold_valid", {31'h0, bus.dout_valid}, 32'h1);
                check("hold_dout", {24'h0, bus.dout}, {24'h0, held});
            end
            if (bus.dout_valid) begin
                if (bus.dout_ready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL extra_byte: got 0x%0h, expected no byte", bus.dout);
                    end else begin
                        check($sformatf("byte%0d", nb), {24'h0, bus.dout}, {24'h0, exp_q.pop_front()});
                    end
                    if (nb < 20) got[nb] = bus.dout;
                    nb++;
                end
                hold_pending = !bus.dout_ready;
                held = bus.dout;
            end else begin
                check("idle_dout", {24'h0, bus.dout}, 32'h0);
                hold_pending = 0;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        bus.start = 1'b1;
        bus.dout_ready = 1'b1;
        bus.sa = 32'hC0A80001;
        bus.da = 32'hC0A800C7;
        bus.protocol = 8'h11;
        bus.payload_len = 16'd95;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {31'h0, bus.dout_valid}, 32'h0);
        check("rst_dout", {24'h0, bus.dout}, 32'h0);
        check("rst_busy", {31'h0, bus.busy}, 32'h0);
        check("rst_done", {31'h0, bus.done}, 32'h0);
        check("rst_err", {31'h0, bus.err}, 32'h0);
        rst = 1'b0;
        bus.start = 1'b0;
        exp_q.delete();
        hold_pending = 0;
        exp_id = 16'h0000;
        nb = 0;
        @(posedge clk);
        #1;
        check("rst_prio_busy", {31'h0, bus.busy}, 32'h0);
    endtask

    task automatic run_hdr(input vec_t v, input bit poke);
        int cyc;
        int k;
        logic [31:0] s;
        for (int i = 0; i < 20; i++) exp_q.push_back(model_byte(i, v, exp_id));
        nb = 0;
        bus.sa = v.sa;
        bus.da = v.da;
        bus.protocol = v.proto;
        bus.payload_len = v.len;
        bus.dout_ready = 1'b1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        cyc = 1;
        while (!bus.dout_valid && cyc < 40) begin
            if (poke && cyc == 3) begin
                bus.start = 1'b1;
                bus.sa = 32'h01020304;
                bus.payload_len = 16'd7;
            end else begin
                bus.start = 1'b0;
                bus.sa = v.sa;
                bus.payload_len = v.len;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        check("latency", cyc, 11);
        k = 0;
        while (nb < 20 && cyc < 400) begin
            bus.dout_ready = v.bp ? bp_pat[k % 4] : 1'b1;
            k++;
            @(posedge clk);
            #1;
            cyc++;
        end
        check("done_pulse", {31'h0, bus.done}, 32'h1);
        check("end_valid", {31'h0, bus.dout_valid}, 32'h0);
        check("end_busy", {31'h0, bus.busy}, 32'h0);
        check("byte_count", nb, 20);
        check("total_len", {16'h0, got[2], got[3]}, {16'h0, v.exp_total});
        check("csum", {16'h0, got[10], got[11]}, {16'h0, v.exp_csum});
        s = 0;
        for (int j = 0; j < 10; j++) s += {16'h0, got[2*j], got[2*j+1]};
        check("rx_sum", {16'h0, fold(s)}, 32'hFFFF);
        $display("header sa=%h len=%0d bp=%0d csum=%h%h", v.sa, v.len, v.bp, got[10], got[11]);
`ifdef IP_ENCODE_ID_EN
        exp_id = exp_id + 16'd1;
`endif
        bus.dout_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        bit saw_valid;
        vec_t v2;

        vecs[0] = '{32'hC0A80001, 32'hC0A800C7, 8'h11, 16'd95,    1'b0, 16'h0073, 16'hB861};
        vecs[1] = '{32'hC0A80001, 32'hC0A800C7, 8'h11, 16'd95,    1'b1, 16'h0073, 16'hB861};
        vecs[2] = '{32'hC0A80001, 32'hC0A800C7, 8'h11, 16'd65515, 1'b0, 16'hFFFF, 16'hB8D4};
        vecs[3] = '{32'h0A000001, 32'h0A000002, 8'h06, 16'd0,     1'b1, 16'h0014, 16'h26E2};

        for (int i = 0; i < 4; i++) begin
            do_reset();
            run_hdr(vecs[i], 1'b0);
        end

        // Oversized payload is rejected with a single err pulse.
        do_reset();
        bus.payload_len = 16'd65516;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("err_pulse", {31'h0, bus.err}, 32'h1);
        check("err_busy", {31'h0, bus.busy}, 32'h0);
        @(posedge clk);
        #1;
        check("err_clear", {31'h0, bus.err}, 32'h0);
        saw_valid = 0;
        repeat (14) begin
            @(posedge clk);
            #1;
            if (bus.dout_valid || bus.busy) saw_valid = 1;
        end
        check("err_no_output", {31'h0, saw_valid}, 32'h0);
        $display("length limit: payload 65516 rejected");

        // Reset after byte 7 aborts the header.
        do_reset();
        for (int i = 0; i < 20; i++) exp_q.push_back(model_byte(i, vecs[0], exp_id));
        nb = 0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        cyc = 0;
        while (nb < 8 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_valid", {31'h0, bus.dout_valid}, 32'h0);
        check("abort_busy", {31'h0, bus.busy}, 32'h0);
        check("abort_done", {31'h0, bus.done}, 32'h0);
        rst = 1'b0;
        exp_q.delete();
        hold_pending = 0;
        exp_id = 16'h0000;
        saw_valid = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.dout_valid) saw_valid = 1;
        end
        check("abort_quiet", {31'h0, saw_valid}, 32'h0);
        $display("reset mid-send: aborted after byte 7");
        run_hdr(vecs[0], 1'b0);

        // Start during CSUM with other fields must be ignored.
        do_reset();
        run_hdr(vecs[0], 1'b1);

        // Back-to-back: second start lands in the done cycle.
        do_reset();
        run_hdr(vecs[0], 1'b0);
        v2 = vecs[0];
`ifdef IP_ENCODE_ID_EN
        v2.exp_csum = 16'hB860;
`endif
        run_hdr(v2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
